zap_copro_dispatch: RTL

//  Sequences one coprocessor transaction at a time from the predecode stage to one of NUM_CP

---
 rtl/zap_copro_dispatch_pkg.sv | 19 +
 rtl/zap_copro_dispatch_if.sv | 38 +++
 rtl/zap_copro_timeout.sv | 34 +++
 rtl/zap_copro_dispatch.sv | 134 +++++++++++++
 4 files changed

// File: rtl/zap_copro_dispatch_pkg.sv
// Coprocessor dispatch shared definitions.
// FSM state encoding, CP numbers and the default slot-to-CP map.
package zap_copro_dispatch_pkg;

  localparam logic [3:0] CP15_ID = 4'd15;
  localparam logic [3:0] CP14_ID = 4'd14;

  // Slot 0 in the LSBs: slot 0 = CP15, slot 1 = CP14.
  localparam logic [7:0] DEF_CP_ID_MAP = {CP14_ID, CP15_ID};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } cp_state_e;

endpackage

// File: rtl/zap_copro_dispatch_if.sv
// Predecode and coprocessor-slot handshake bundle.
// master: dispatcher side; slave: predecode + coprocessor slots.
interface zap_copro_dispatch_if #(
  parameter int NUM_CP = 2
);

  logic              i_copro_dav;
  logic [31:0]       i_copro_word;
  logic              o_copro_done;
  logic              o_copro_undef;
  logic [NUM_CP-1:0] o_cp_req;
  logic [31:0]       o_cp_word;
  logic [NUM_CP-1:0] i_cp_ack;
  logic              o_busy;

  modport master (
    input  i_copro_dav,
    input  i_copro_word,
    input  i_cp_ack,
    output o_copro_done,
    output o_copro_undef,
    output o_cp_req,
    output o_cp_word,
    output o_busy
  );

  modport slave (
    output i_copro_dav,
    output i_copro_word,
    output i_cp_ack,
    input  o_copro_done,
    input  o_copro_undef,
    input  o_cp_req,
    input  o_cp_word,
    input  o_busy
  );

endinterface

// File: rtl/zap_copro_timeout.sv
// Wait-state counter: load TIMEOUT, decrement, clear.
// Ports: i_clk, i_reset, i_load, i_dec, i_clr; o_expire = next dec hits 0.
module zap_copro_timeout #(
  parameter  int TIMEOUT = 16,
  localparam int W       = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      i_clr:  cnt_d = '0;
      i_load: cnt_d = W'(TIMEOUT);
      i_dec:  if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_expire = (cnt_q == W'(1));

endmodule

// File: rtl/zap_copro_dispatch.sv
// One-at-a-time coprocessor dispatcher from predecode to NUM_CP slots.
// Ports: i_clk, i_reset, bus (dav/word in, done/undef out, req/word/ack to slots, busy).
module zap_copro_dispatch
  import zap_copro_dispatch_pkg::*;
#(
  parameter int                  NUM_CP    = 2,
  parameter logic [4*NUM_CP-1:0] CP_ID_MAP = (4*NUM_CP)'(DEF_CP_ID_MAP),
  parameter int                  TIMEOUT   = 16
) (
  input logic                  i_clk,
  input logic                  i_reset,
  zap_copro_dispatch_if.master bus
);

  cp_state_e         state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [NUM_CP-1:0] sel_q, sel_d;
  logic [NUM_CP-1:0] req_q, req_d;
  logic [NUM_CP-1:0] hit;
  logic              pend_q, pend_d;
  logic              done_q, undef_q, busy_q;
  logic              cnt_load, cnt_dec, cnt_clr;
  logic              expire, ack_hit, found;

  // Lowest slot wins when two slots carry the same CP number.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (!found &&
          CP_ID_MAP[4*i +: 4] == bus.i_copro_word[11:8]) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign ack_hit = |(bus.i_cp_ack & sel_q);

  zap_copro_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (cnt_load),
    .i_dec    (cnt_dec),
    .i_clr    (cnt_clr),
    .o_expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    sel_d    = sel_q;
    req_d    = req_q;
    pend_d   = pend_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_copro_dav) begin
          word_d  = bus.i_copro_word;
          sel_d   = hit;
          pend_d  = ~found;
          state_d = found ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (!bus.i_copro_dav) begin
          state_d = ST_IDLE;
        end else begin
          req_d    = sel_q;
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Pipeline clear beats everything; ack beats expiry.
        if (!bus.i_copro_dav) begin
          req_d   = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_hit) begin
          req_d   = '0;
          cnt_clr = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
          if (expire) begin
            req_d   = '0;
            pend_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.i_copro_dav) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      req_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      undef_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      done_q  <= (state_q == ST_DONE);
      undef_q <= (state_q == ST_DONE) && pend_q;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.o_copro_done  = done_q;
  assign bus.o_copro_undef = undef_q;
  assign bus.o_cp_req      = req_q;
  assign bus.o_cp_word     = word_q;
  assign bus.o_busy        = busy_q;

endmodule
